// File: rtl/lfsr_period_chk.sv
// lfsr_period_chk
// Measures the period of an upstream 4-bit LFSR by watching its result bus.
// On an accepted start the current value is captured as a reference. Valid
// samples are then counted until one of these happens:
//   - the reference value comes round again (period found),
//   - the all-zero lockup state appears, or
//   - MAX_CYCLES samples pass without a repeat (timeout).
// A mirrored upstream load strobe aborts a measurement in progress.
//
// Optional feature macro: LFSR_PERIOD_CHK_SEEN_MAP_EN
//   When defined, a seen_map[15:0] output is added. It records every value
//   captured as the reference or sampled during a measurement.
//   When undefined, that port and its logic are absent.

module lfsr_period_chk #(
  parameter int MAX_CYCLES = 31,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       lfsr_in,
  input  logic             lfsr_valid,
  input  logic             lfsr_load,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             lockup,
  output logic             timeout
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
  ,
  output logic [15:0]      seen_map
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registered state and results
  state_t           state_r;
  logic [3:0]       ref_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             lockup_r;
  logic             timeout_r;
  logic             busy_r;
  logic             done_r;

  // Next-state values
  state_t           state_s;
  logic [3:0]       ref_s;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] period_s;
  logic             lockup_s;
  logic             timeout_s;
  logic             busy_s;
  logic             done_s;

  // cnt_r never exceeds MAX_CYCLES-1, so cnt_r+1 always fits in CNT_W bits.
  logic [CNT_W-1:0] cnt_inc_s;
  logic             in_zero_s;
  logic             in_match_s;

`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
  logic [15:0]      seen_map_r;
  logic [15:0]      seen_map_s;

  // One-hot decode of a 4-bit LFSR value into its seen_map bit.
  function automatic logic [15:0] value_bit(input logic [3:0] v);
    value_bit = 16'd1 << v;
  endfunction
`endif

  // Shared sample qualifiers used by the decision logic.
  always_comb begin
    cnt_inc_s  = cnt_r + CNT_ONE;
    in_zero_s  = (lfsr_in == 4'd0);
    in_match_s = (lfsr_in == ref_r);
  end

  // Next-state and next-result decode: priority in RUN is load > match > zero > timeout.
  always_comb begin
    state_s   = state_r;
    ref_s     = ref_r;
    cnt_s     = cnt_r;
    period_s  = period_r;
    lockup_s  = lockup_r;
    timeout_s = timeout_r;
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
    seen_map_s = seen_map_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          period_s  = CNT_ZERO;
          timeout_s = 1'b0;
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
          seen_map_s = 16'd0;
`endif
          if (!in_zero_s) begin
            // A non-zero seed is captured as the reference to wait for.
            ref_s    = lfsr_in;
            cnt_s    = CNT_ZERO;
            lockup_s = 1'b0;
            state_s  = ST_RUN;
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
            seen_map_s = value_bit(lfsr_in);
`endif
          end else begin
            // The LFSR is already stuck at zero; report lockup immediately.
            lockup_s = 1'b1;
            state_s  = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (lfsr_load) begin
          // Upstream reloaded its register, so this measurement is meaningless.
          period_s  = CNT_ZERO;
          lockup_s  = 1'b0;
          timeout_s = 1'b0;
          state_s   = ST_IDLE;
        end else if (lfsr_valid) begin
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
          seen_map_s = seen_map_r | value_bit(lfsr_in);
`endif
          if (in_match_s) begin
            period_s = cnt_inc_s;
            state_s  = ST_DONE;
          end else if (in_zero_s) begin
            lockup_s = 1'b1;
            period_s = cnt_inc_s;
            state_s  = ST_DONE;
          end else if (cnt_inc_s == MAX_CNT) begin
            timeout_s = 1'b1;
            period_s  = MAX_CNT;
            state_s   = ST_DONE;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_DONE: begin
        // Results are held until acknowledged; start has no effect here.
        if (ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end

      default: begin
        // An unreachable encoding falls back to a clean idle.
        state_s   = ST_IDLE;
        ref_s     = 4'd0;
        cnt_s     = CNT_ZERO;
        period_s  = CNT_ZERO;
        lockup_s  = 1'b0;
        timeout_s = 1'b0;
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
        seen_map_s = 16'd0;
`endif
      end
    endcase

    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ref_r     <= 4'd0;
      cnt_r     <= CNT_ZERO;
      period_r  <= CNT_ZERO;
      lockup_r  <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ref_r     <= ref_s;
      cnt_r     <= cnt_s;
      period_r  <= period_s;
      lockup_r  <= lockup_s;
      timeout_r <= timeout_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
  // Seen-value map register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_map_r <= 16'd0;
    end else begin
      seen_map_r <= seen_map_s;
    end
  end

  assign seen_map = seen_map_r;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign period  = period_r;
  assign lockup  = lockup_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_lfsr_period_chk.sv
// tb_lfsr_period_chk
// Self-checking bench for lfsr_period_chk.
// The reference model works on whole measurements. It keeps the samples of
// the current measurement in a queue, and judges each new sample by the
// queue length against the reference value and MAX_CYCLES.
// Directed scenarios are followed by a randomized run.
// Optional feature macro: LFSR_PERIOD_CHK_SEEN_MAP_EN (enables seen_map checks).

module tb_lfsr_period_chk;

  localparam int MAX_CYCLES = 31;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       lfsr_in;
  logic             lfsr_valid;
  logic             lfsr_load;
  logic             start;
  logic             ack;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             lockup;
  logic             timeout;
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
  logic [15:0]      seen_map;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state: 0 = idle, 1 = measuring, 2 = result held
  int         m_mode = 0;
  logic [3:0] m_ref = 4'd0;
  logic [3:0] m_samples[$];
  int         m_period = 0;
  logic       m_lockup = 1'b0;
  logic       m_timeout = 1'b0;
  logic [15:0] m_seen = 16'd0;

  lfsr_period_chk #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lfsr_in(lfsr_in),
    .lfsr_valid(lfsr_valid),
    .lfsr_load(lfsr_load),
    .start(start),
    .ack(ack),
    .busy(busy),
    .done(done),
    .period(period),
    .lockup(lockup),
    .timeout(timeout)
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
    ,
    .seen_map(seen_map)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream x^4+x^3+1 LFSR step
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // Apply one clock edge's worth of inputs to the reference model.
  task automatic model_edge(input logic r, input logic s, input logic a,
                            input logic v, input logic ld, input logic [3:0] d);
    if (r) begin
      m_mode = 0; m_ref = 4'd0; m_samples.delete();
      m_period = 0; m_lockup = 1'b0; m_timeout = 1'b0; m_seen = 16'd0;
    end else begin
      case (m_mode)
        0: if (s) begin
          m_period = 0; m_timeout = 1'b0; m_seen = 16'd0;
          if (d != 4'd0) begin
            m_ref = d; m_samples.delete(); m_lockup = 1'b0;
            m_seen[d] = 1'b1; m_mode = 1;
          end else begin
            m_lockup = 1'b1; m_mode = 2;
          end
        end
        1: if (ld) begin
          m_mode = 0; m_period = 0; m_lockup = 1'b0; m_timeout = 1'b0;
        end else if (v) begin
          m_samples.push_back(d);
          m_seen[d] = 1'b1;
          if (d == m_ref) begin
            m_period = m_samples.size(); m_mode = 2;
          end else if (d == 4'd0) begin
            m_lockup = 1'b1; m_period = m_samples.size(); m_mode = 2;
          end else if (m_samples.size() == MAX_CYCLES) begin
            m_timeout = 1'b1; m_period = MAX_CYCLES; m_mode = 2;
          end
        end
        2: if (a) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  // Drive inputs, take one edge, advance the model, compare just after the edge.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic v, input logic ld, input logic [3:0] d);
    reset = r; start = s; ack = a; lfsr_valid = v; lfsr_load = ld; lfsr_in = d;
    @(posedge clk);
    model_edge(r, s, a, v, ld, d);
    #1;
    check_val("busy", 32'(busy), 32'(m_mode == 1));
    check_val("done", 32'(done), 32'(m_mode == 2));
    if (m_mode == 2) begin
      check_val("period", 32'(period), 32'(m_period));
      check_val("lockup", 32'(lockup), 32'(m_lockup));
      check_val("timeout", 32'(timeout), 32'(m_timeout));
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
      check_val("seen_map", 32'(seen_map), 32'(m_seen));
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] s;
    int n;
    logic v;
    logic alt;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_period", 32'(period), 32'd0);
    check_val("rst_lockup", 32'(lockup), 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);

    // Maximal-length LFSR seeded with 0001 gives period 15
    s = 4'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    check_val("run_busy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      s = lfsr_next(s);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
      n++;
    end
    check_val("lfsr_samples", 32'(n), 32'd15);
    check_val("lfsr_done", 32'(done), 32'd1);
    check_val("lfsr_period", 32'(period), 32'd15);
    check_val("lfsr_lockup", 32'(lockup), 32'd0);
    check_val("lfsr_timeout", 32'(timeout), 32'd0);
`ifdef LFSR_PERIOD_CHK_SEEN_MAP_EN
    check_val("lfsr_seen", 32'(seen_map), 32'h0000FFFE);
`endif
    // Start while done is ignored, results held
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
    check_val("done_hold", 32'(period), 32'd15);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check_val("ack_idle", 32'(done), 32'd0);

    // Zero at start: immediate lockup
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("zero_done", 32'(done), 32'd1);
    check_val("zero_lockup", 32'(lockup), 32'd1);
    check_val("zero_period", 32'(period), 32'd0);
    // start and ack together: ack wins, start not captured
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    check_val("ackwin_busy", 32'(busy), 32'd0);
    check_val("ackwin_done", 32'(done), 32'd0);

    // Valid toggling: period still 15, done on the 30th cycle counting the start edge
    s = 4'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    n = 1; v = 1'b1;
    while (!done && n < 60) begin
      if (v) s = lfsr_next(s);
      step(1'b0, 1'b0, 1'b0, v, 1'b0, s);
      n++;
      v = ~v;
    end
    check_val("toggle_cycles", 32'(n), 32'd30);
    check_val("toggle_period", 32'(period), 32'd15);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Timeout: value never returns to the reference
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < MAX_CYCLES; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2 + 4'(i % 2));
    check_val("to_timeout", 32'(timeout), 32'd1);
    check_val("to_period", 32'(period), 32'(MAX_CYCLES));
    check_val("to_lockup", 32'(lockup), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Load pulse at sample 7 aborts; done never rises
    s = 4'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    for (int i = 0; i < 6; i++) begin
      s = lfsr_next(s);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    check_val("load_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
      if (done) n++;
    end
    check_val("load_nodone", 32'(n), 32'd0);

    // Reset mid-measurement clears everything
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_done", 32'(done), 32'd0);
    check_val("mrst_period", 32'(period), 32'd0);
    check_val("mrst_flags", 32'({lockup, timeout}), 32'd0);

    // Randomized traffic against the model
    alt = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) alt = ~alt;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 59) == 0),
           alt ? (4'd8 + 4'($urandom_range(0, 1))) : 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
